// File: rtl/alert_level_gen.sv
// alert_level_gen: breach/clear/force_red -> one-hot green/yellow/red alert level; also exposes state, timer and a saturating breach_count
module alert_level_gen #(
  parameter int YELLOW_HOLD = 20,
  parameter int COOL_CYCLES = 10,
  parameter int STRIKES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       breach,
  input  logic       clear_req,
  input  logic       force_red,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [1:0] state,
  output logic [5:0] timer,
  output logic [7:0] breach_count
);
  typedef enum logic [1:0] {GREEN, YELLOW, RED, COOLDOWN} st_t;
  st_t st, st_n;
  logic [5:0] timer_n;
  logic [2:0] strikes, strikes_n;
  logic escalate;
  assign escalate = ({1'b0, strikes} + 4'd1) >= 4'(STRIKES);
  assign state = st;
  assign green = st == GREEN;
  assign yellow = st == YELLOW || st == COOLDOWN;
  assign red = st == RED;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= GREEN;
      timer <= '0;
      strikes <= '0;
      breach_count <= '0;
    end else begin
      st <= st_n;
      timer <= timer_n;
      strikes <= strikes_n;
      breach_count <= breach_count + 8'(breach && breach_count != 8'hff);
    end
  always_comb begin
    st_n = st;
    timer_n = timer;
    strikes_n = strikes;
    if (force_red) begin
      st_n = RED;
      timer_n = '0;
      strikes_n = '0;
    end else
      case (st)
        GREEN:
          if (breach) begin
            strikes_n = 3'd1;
            st_n = STRIKES == 1 ? RED : YELLOW;
            timer_n = STRIKES == 1 ? 6'd0 : 6'(YELLOW_HOLD - 1);
          end
        YELLOW:
          if (breach) begin
            st_n = escalate ? RED : YELLOW;
            timer_n = escalate ? 6'd0 : 6'(YELLOW_HOLD - 1);
            strikes_n = escalate ? 3'd0 : strikes + 3'd1;
          end else if (timer == 0) begin
            st_n = GREEN;
            strikes_n = '0;
          end else
            timer_n = timer - 6'd1;
        RED: begin
          timer_n = '0;
          if (!breach && clear_req) begin
            st_n = COOLDOWN;
            timer_n = 6'(COOL_CYCLES - 1);
          end
        end
        default:
          if (breach) begin
            st_n = RED;
            timer_n = '0;
          end else if (timer == 0)
            st_n = GREEN;
          else
            timer_n = timer - 6'd1;
      endcase
  end
endmodule

// File: tb/tb_alert_level_gen.sv
// tb_alert_level_gen: directed self-checking bench for alert_level_gen
module tb_alert_level_gen;
  logic clock = 0, reset = 1, breach = 0, clear_req = 0, force_red = 0;
  logic green, yellow, red;
  logic [1:0] state;
  logic [5:0] timer;
  logic [7:0] breach_count;
  int tests = 0, fails = 0;
  alert_level_gen dut (
    .clock(clock), .reset(reset), .breach(breach), .clear_req(clear_req), .force_red(force_red),
    .green(green), .yellow(yellow), .red(red), .state(state), .timer(timer), .breach_count(breach_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic [1:0] s, input logic [5:0] t);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".lines"}, 32'({green, yellow, red}), 32'({s == 2'd0, s == 2'd1 || s == 2'd3, s == 2'd2}));
    chk({tag, ".timer"}, 32'(timer), 32'(t));
  endtask
  task automatic cyc(input logic b, input logic c, input logic f);
    breach = b;
    clear_req = c;
    force_red = f;
    @(posedge clock);
    #1;
    breach = 0;
    clear_req = 0;
    force_red = 0;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #3 reset = 0;
    @(posedge clock);
    #1;
    chk_st("reset", 2'd0, 6'd0);
    chk("reset.bc", 32'(breach_count), 0);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0);
      chk_st("idle", 2'd0, 6'd0);
      chk("idle.bc", 32'(breach_count), 0);
    end
    cyc(1, 0, 0);
    chk_st("y_entry", 2'd1, 6'd19);
    chk("y_entry.bc", 32'(breach_count), 1);
    for (int k = 1; k < 20; k++) begin
      cyc(0, 0, 0);
      chk_st("y_count", 2'd1, 6'(19 - k));
    end
    cyc(0, 0, 0);
    chk_st("y_expire", 2'd0, 6'd0);
    cyc(0, 1, 0);
    chk_st("green_clear_ignored", 2'd0, 6'd0);
    cyc(1, 0, 0);
    chk_st("strike1", 2'd1, 6'd19);
    repeat (4) cyc(0, 0, 0);
    chk_st("strike1_wait", 2'd1, 6'd15);
    cyc(1, 0, 0);
    chk_st("strike2_red", 2'd2, 6'd0);
    chk("strike2.bc", 32'(breach_count), 3);
    cyc(0, 1, 0);
    chk_st("cool_entry", 2'd3, 6'd9);
    repeat (9) cyc(0, 0, 0);
    chk_st("cool_last", 2'd3, 6'd0);
    cyc(0, 1, 0);
    chk_st("cool_expire", 2'd0, 6'd0);
    cyc(0, 0, 1);
    chk_st("force", 2'd2, 6'd0);
    cyc(1, 1, 0);
    chk_st("red_breach_clear", 2'd2, 6'd0);
    chk("red_breach_clear.bc", 32'(breach_count), 4);
    cyc(0, 1, 0);
    chk_st("red_clear", 2'd3, 6'd9);
    repeat (5) cyc(0, 0, 0);
    chk_st("cool_t4", 2'd3, 6'd4);
    cyc(1, 0, 0);
    chk_st("cool_breach", 2'd2, 6'd0);
    chk("cool_breach.bc", 32'(breach_count), 5);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk_st("cool_force", 2'd2, 6'd0);
    #2 reset = 1;
    #3 reset = 0;
    @(posedge clock);
    #1;
    cyc(1, 0, 1);
    chk_st("force_breach", 2'd2, 6'd0);
    chk("force_breach.bc", 32'(breach_count), 1);
    chk("force_breach.strikes", 32'(dut.strikes), 0);
    for (int i = 0; i < 300; i++) cyc(1, 0, 0);
    chk_st("sat_red", 2'd2, 6'd0);
    chk("sat.bc", 32'(breach_count), 255);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk_st("sat_red_again", 2'd2, 6'd0);
    chk("sat_hold.bc", 32'(breach_count), 255);
    #2 reset = 1;
    #1;
    chk_st("async_reset", 2'd0, 6'd0);
    chk("async_reset.bc", 32'(breach_count), 0);
    @(negedge clock);
    reset = 0;
    cyc(0, 0, 0);
    chk_st("post_reset", 2'd0, 6'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alert_level_gen.md
Name: alert_level_gen

Overview:
- Drives the green/yellow/red alert lines consumed by the scp_079 containment FSM. This block is the producer side of that status interface.
- Converts breach-sensor pulses, an operator clear request and a manual override into a one-hot alert level, using hold and cooldown timers.
- Exposes its state, timer and a breach counter for monitoring and debug.

Parameters:
- YELLOW_HOLD, 20: cycles spent in YELLOW without a further breach before returning to GREEN. Legal range 1..63.
- COOL_CYCLES, 10: cycles spent in COOLDOWN after a clear before returning to GREEN. Legal range 1..63.
- STRIKES, 2: number of breaches within one alert episode that escalates to RED. Legal range 1..7.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- breach  input  1  breach sensor event, sampled every cycle; each high cycle is one event.
- clear_req  input  1  operator clear; honoured only in RED.
- force_red  input  1  manual override to RED.
- green  output  1  alert line, high only in GREEN.
- yellow  output  1  alert line, high in YELLOW or COOLDOWN.
- red  output  1  alert line, high only in RED.
- state  output  2  0=GREEN, 1=YELLOW, 2=RED, 3=COOLDOWN.
- timer  output  6  down-counter for the current state.
- breach_count  output  8  saturating count of breach cycles since reset.

Behaviour:
- Registers: state, timer, strikes[2:0], breach_count.
- green/yellow/red decode combinationally from the state register. Exactly one is high at all times.
- Reset (asynchronous) sets state=GREEN, timer=0, strikes=0, breach_count=0, so green=1, yellow=0, red=0.
- Releasing reset is synchronous to the next rising clock edge.
- All transitions occur on the rising edge. Input priority: force_red > breach > clear_req > timer expiry.
- Outputs reflect an input sampled at edge N immediately after edge N; latency is one cycle.
- force_red, any state: go to RED, timer=0, strikes=0.
- GREEN:
  - On breach: strikes=1.
  - If STRIKES==1, go to RED with timer=0.
  - Otherwise go to YELLOW with timer=YELLOW_HOLD-1.
  - clear_req is ignored.
- YELLOW:
  - On breach: if strikes+1 >= STRIKES, go to RED with timer=0 and strikes=0. Otherwise strikes=strikes+1 and timer reloads to YELLOW_HOLD-1.
  - Else if timer==0: go to GREEN, strikes=0.
  - Else timer decrements by 1.
- RED:
  - breach holds RED; this includes breach and clear_req in the same cycle.
  - Else on clear_req: go to COOLDOWN with timer=COOL_CYCLES-1.
  - timer stays 0.
- COOLDOWN:
  - On breach: go to RED, timer=0.
  - Else if timer==0: go to GREEN.
  - Else timer decrements by 1.
  - clear_req is ignored.
- YELLOW dwell is exactly YELLOW_HOLD cycles and COOLDOWN dwell is exactly COOL_CYCLES cycles when no other event occurs.
- breach_count increments on every cycle breach=1 in any state, including during force_red. It saturates at 255 and never wraps.
- Reset asserted mid-episode, in any state, returns to GREEN immediately, without waiting for a clock edge.

Test Plan:
- Reset then idle 30 cycles -> green=1, state=0, timer=0, breach_count=0 throughout.
- One breach pulse, then idle -> yellow=1 and timer=19 on the next cycle. timer counts down to 0; 20 cycles after entry, green=1. breach_count=1.
- Two breach pulses 5 cycles apart -> YELLOW after the first pulse, red=1 on the cycle after the second. Then clear_req -> COOLDOWN with timer=9; 10 cycles later green=1.
- In RED, assert breach and clear_req together -> stays RED. A clear_req alone next cycle -> COOLDOWN. A breach at timer=4 -> back to RED.
- force_red asserted together with breach while in GREEN -> red=1 next cycle, strikes=0, breach_count=1.
- 300 consecutive breach cycles -> breach_count holds at 255. Assert reset asynchronously between clock edges mid-RED -> green=1 and breach_count=0 before the next edge.
